ll_keypad: RTL and testbench

LL_KEYPAD -- requirements
Module: ll_keypad

---
 rtl/ll_keypad.sv | 153 +++++++++++++++
 tb/tb_ll_keypad.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ll_keypad.sv
// Debounced 20-key keypad scanner with thrust/display actions for a lunar-lander panel.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module ll_keypad #(
    parameter int DEBOUNCE = 2,
    parameter int REPEAT   = 50
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [19:0] in,
    output logic [4:0]  keycode,
    output logic        strobe,
    output logic [3:0]  thrust,
    output logic [1:0]  disp_mode
);

`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE);
    localparam logic [7:0] REP_LAST = 8'(REPEAT - 1);

    typedef enum logic [1:0] {IDLE, ARMED, HELD, RELEASE} state_t;

    state_t      state, state_next;
    logic [19:0] sync_meta, sync;
    logic [3:0]  cnt, cnt_next;
    logic [4:0]  cand, cand_reg, cand_next;
    logic [7:0]  rep_cnt, rep_next;
    logic        fire;

    // Highest set bit wins when several keys are down together.
    always_comb begin
        cand = '0;
        for (int i = 0; i < 20; i++) begin
            if (sync[i]) cand = 5'(i);
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync      <= '0;
            state     <= IDLE;
            cnt       <= '0;
            cand_reg  <= '0;
            rep_cnt   <= '0;
        end else begin
            sync_meta <= in;
            sync      <= sync_meta;
            state     <= state_next;
            cnt       <= cnt_next;
            cand_reg  <= cand_next;
            rep_cnt   <= rep_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand_reg;
        rep_next   = rep_cnt;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                rep_next = '0;
                if (sync != '0) begin
                    cand_next = cand;
                    cnt_next  = 4'd1;
                    if (DEB_LAST == 4'd1) begin
                        state_next = HELD;
                        fire       = 1'b1;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (sync == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cand != cand_reg) begin
                    cand_next = cand;
                    cnt_next  = 4'd1;
                end else begin
                    cnt_next = cnt + 4'd1;
                    if (cnt + 4'd1 == DEB_LAST) begin
                        state_next = HELD;
                        fire       = 1'b1;
                    end
                end
            end
            HELD: begin
                if (sync == '0) begin
                    rep_next = '0;
                    if (DEB_LAST == 4'd1) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = RELEASE;
                        cnt_next   = 4'd1;
                    end
                end else if (cand != cand_reg) begin
                    // A second key joining a held one never produces its own strobe.
                    rep_next = '0;
                end else if (REPEAT_ON) begin
                    if (rep_cnt == REP_LAST) begin
                        rep_next = '0;
                        fire     = 1'b1;
                    end else begin
                        rep_next = rep_cnt + 8'd1;
                    end
                end
            end
            RELEASE: begin
                if (sync != '0) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                    if (cnt + 4'd1 == DEB_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            strobe    <= 1'b0;
            keycode   <= '0;
            thrust    <= 4'd5;
            disp_mode <= 2'd0;
        end else begin
            strobe <= fire;
            if (fire) begin
                keycode <= cand;
                if (cand <= 5'd9) thrust <= cand[3:0];
                // Keys 16..19 select displays in reverse order (19 = ALT).
                if (cand >= 5'd16) disp_mode <= 2'(5'd19 - cand);
            end
        end
    end

endmodule

// File: tb/tb_ll_keypad.sv
// Scoreboard bench for ll_keypad: expected strobes are queued with their due cycle.
module tb_ll_keypad;

    typedef struct {
        int key;
        int thr;
        int disp;
        int at;
    } exp_t;

    logic        hz100 = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] in = '0;
    logic [4:0]  keycode;
    logic        strobe;
    logic [3:0]  thrust;
    logic [1:0]  disp_mode;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   strobes_seen = 0;
    int   model_thr = 5;
    int   model_disp = 0;
    logic prev_strobe = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    ll_keypad #(.DEBOUNCE(2), .REPEAT(10)) dut (
        .hz100(hz100), .reset(reset), .in(in),
        .keycode(keycode), .strobe(strobe), .thrust(thrust), .disp_mode(disp_mode)
    );

    always #5 hz100 = ~hz100;
    always @(posedge hz100) cyc <= cyc + 1;

    // Reference model of the key actions; pushes the expected strobe.
    task automatic push_expect(input int key, input int at);
        exp_t e;
        if (key <= 9) model_thr = key;
        if (key >= 16) model_disp = 19 - key;
        e.key = key; e.thr = model_thr; e.disp = model_disp; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic hold_bus(input logic [19:0] v, input int n);
        in = v;
        repeat (n) @(negedge hz100);
    endtask

    always @(negedge hz100) begin
        if (strobe) begin
            strobes_seen++;
            $display("strobe cyc=%0d keycode=%0d thrust=%0d disp_mode=%0d", cyc, keycode, thrust, disp_mode);
            checks++;
            if (prev_strobe) begin
                failures++;
                $display("FAIL back_to_back_strobe cyc=%0d got two consecutive, required none", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d keycode=%0d, required no strobe", cyc, keycode);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e.at) begin
                    failures++;
                    $display("FAIL strobe_cycle got %0d required %0d", cyc, mon_e.at);
                end
                checks++;
                if (int'(keycode) !== mon_e.key) begin
                    failures++;
                    $display("FAIL keycode got %0d required %0d", keycode, mon_e.key);
                end
                checks++;
                if (int'(thrust) !== mon_e.thr) begin
                    failures++;
                    $display("FAIL thrust_on_strobe got %0d required %0d", thrust, mon_e.thr);
                end
                checks++;
                if (int'(disp_mode) !== mon_e.disp) begin
                    failures++;
                    $display("FAIL disp_on_strobe got %0d required %0d", disp_mode, mon_e.disp);
                end
            end
        end
        prev_strobe = strobe;
    end

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_strobe got %0d outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in = '0;
        repeat (3) @(negedge hz100);
        checks++;
        if (thrust !== 4'd5 || disp_mode !== 2'd0 || strobe !== 1'b0 || keycode !== 5'd0) begin
            failures++;
            $display("FAIL reset_values got thr=%0d disp=%0d str=%0d key=%0d required 5 0 0 0",
                     thrust, disp_mode, strobe, keycode);
        end
        in = 20'h80000;
        for (int i = 0; i < 4; i++) begin
            @(negedge hz100);
            checks++;
            if (strobe !== 1'b0) begin
                failures++;
                $display("FAIL strobe_in_reset got %0d required 0", strobe);
            end
        end
        reset = 1'b1;
        push_expect(19, cyc + 4);
        hold_bus(20'h80000, 8);
        hold_bus('0, 8);
        check_drained("reset_held_key");
    endtask

    task automatic test_single_press();
        push_expect(0, cyc + 4);
        hold_bus(20'h00001, 6);
        hold_bus('0, 8);
        check_drained("single_press");
        checks++;
        if (thrust !== 4'd0) begin
            failures++;
            $display("FAIL single_press_thrust got %0d required 0", thrust);
        end
    endtask

    task automatic test_disp_modes();
        push_expect(18, cyc + 4);
        hold_bus(20'h40000, 5);
        hold_bus('0, 5);
        push_expect(17, cyc + 4);
        hold_bus(20'h20000, 5);
        hold_bus('0, 5);
        check_drained("disp_modes");
        checks++;
        if (disp_mode !== 2'd2) begin
            failures++;
            $display("FAIL disp_modes_final got %0d required 2", disp_mode);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) hold_bus((i % 2 == 0) ? 20'h00200 : 20'h0, 1);
        hold_bus('0, 5);
        checks++;
        if (int'(thrust) !== model_thr) begin
            failures++;
            $display("FAIL bounce_thrust got %0d required %0d", thrust, model_thr);
        end
        push_expect(9, cyc + 4);
        hold_bus(20'h00220, 6);
        hold_bus('0, 8);
        check_drained("bounce_then_pair");
        checks++;
        if (thrust !== 4'd9) begin
            failures++;
            $display("FAIL pair_thrust got %0d required 9", thrust);
        end
    endtask

    task automatic test_release_glitch();
        push_expect(5, cyc + 4);
        hold_bus(20'h00020, 5);
        hold_bus('0, 1);
        hold_bus(20'h00020, 5);
        hold_bus('0, 8);
        check_drained("release_glitch");
        checks++;
        if (thrust !== 4'd5) begin
            failures++;
            $display("FAIL glitch_thrust got %0d required 5", thrust);
        end
    endtask

    task automatic test_repeat();
        int start_seen;
        int want;
        start_seen = strobes_seen;
        push_expect(3, cyc + 4);
`ifdef KEYPAD_REPEAT_EN
        want = 4;
        push_expect(3, cyc + 14);
        push_expect(3, cyc + 24);
        push_expect(3, cyc + 34);
`else
        want = 1;
`endif
        hold_bus(20'h00008, 40);
        hold_bus('0, 8);
        check_drained("repeat");
        checks++;
        if (strobes_seen - start_seen !== want) begin
            failures++;
            $display("FAIL repeat_count got %0d required %0d", strobes_seen - start_seen, want);
        end
        checks++;
        if (thrust !== 4'd3) begin
            failures++;
            $display("FAIL repeat_thrust got %0d required 3", thrust);
        end
    endtask

    task automatic test_highest_wins();
        push_expect(16, cyc + 4);
        hold_bus(20'h11000, 6);
        hold_bus('0, 8);
        check_drained("highest_wins");
        checks++;
        if (disp_mode !== 2'd3) begin
            failures++;
            $display("FAIL highest_disp got %0d required 3", disp_mode);
        end
    endtask

    task automatic test_reset_abort();
        hold_bus(20'h00080, 3);
        reset = 1'b0;
        model_thr = 5;
        model_disp = 0;
        hold_bus(20'h00080, 2);
        checks++;
        if (strobe !== 1'b0 || thrust !== 4'd5) begin
            failures++;
            $display("FAIL abort_in_reset got str=%0d thr=%0d required 0 5", strobe, thrust);
        end
        in = '0;
        reset = 1'b1;
        hold_bus('0, 8);
        check_drained("reset_abort");
        checks++;
        if (thrust !== 4'd5 || disp_mode !== 2'd0 || keycode !== 5'd0) begin
            failures++;
            $display("FAIL abort_state got thr=%0d disp=%0d key=%0d required 5 0 0",
                     thrust, disp_mode, keycode);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_disp_modes();
        test_bounce();
        test_release_glitch();
        test_repeat();
        test_highest_wins();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
